// File: rtl/digit_entry_display.sv
// rtl/digit_entry_display.sv - two-digit decimal entry buffer with seven-segment display and overflow blink
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   i_num        4-bit digit code from the button layer
//   i_DV         one-cycle strobe qualifying i_num
//   i_clear      one-cycle strobe, discard the entry
//   i_enter      one-cycle strobe, commit the entry
//   o_operand    committed binary operand, 0..99
//   o_operand_DV one-cycle strobe, o_operand updated
//   o_overflow   sticky, a third digit was attempted
//   o_bad_digit  one-cycle strobe, a code above 9 was rejected
//   o_seg_tens   left display {a..g}, active-low
//   o_seg_ones   right display {a..g}, active-low

module digit_entry_display #(
    parameter int MAX_DIGITS   = 2,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_num,
    input  logic       i_DV,
    input  logic       i_clear,
    input  logic       i_enter,
    output logic [6:0] o_operand,
    output logic       o_operand_DV,
    output logic       o_overflow,
    output logic       o_bad_digit,
    output logic [6:0] o_seg_tens,
    output logic [6:0] o_seg_ones
);

    localparam int              BW         = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [1:0]      COUNT_FULL = 2'(MAX_DIGITS);
    localparam logic [6:0]      SEG_BLANK  = 7'b1111111;

    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [1:0]    count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          bad_digit_q, bad_digit_d;
    logic [6:0]    operand_q, operand_d;
    logic          operand_dv_q, operand_dv_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;
    logic [6:0]    seg_tens_q, seg_tens_d;
    logic [6:0]    seg_ones_q, seg_ones_d;

    logic          digit_bad;
    logic [6:0]    tens_ext;
    logic [6:0]    entry_value;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    always_comb begin
        digit_bad = i_DV && (i_num > 4'd9);

        // tens*10 as shift-and-add; 9*10+9 = 99 fits in 7 bits
        tens_ext = {3'b000, tens_q};
        case (count_q)
            2'd0:    entry_value = 7'd0;
            2'd1:    entry_value = {3'b000, ones_q};
            default: entry_value = (tens_ext << 3) + (tens_ext << 1) + {3'b000, ones_q};
        endcase

        tens_d       = tens_q;
        ones_d       = ones_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        operand_d    = operand_q;
        operand_dv_d = 1'b0;
        bad_digit_d  = digit_bad;

        // blink timebase only runs while overflow is flagged
        if (overflow_q) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
                blink_on_d  = blink_on_q;
            end
        end else begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end

        // a rejected code freezes the entry even against clear/enter
        if (digit_bad) begin
            tens_d = tens_q;
        end else if (i_clear || i_enter) begin
            if (!i_clear) begin
                operand_d    = entry_value;
                operand_dv_d = 1'b1;
            end
            tens_d      = 4'd0;
            ones_d      = 4'd0;
            count_d     = 2'd0;
            overflow_d  = 1'b0;
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (i_DV) begin
            if (count_q == COUNT_FULL) begin
                overflow_d = 1'b1;
            end else if (count_q == 2'd0) begin
                ones_d  = i_num;
                count_d = 2'd1;
            end else begin
                tens_d  = ones_q;
                ones_d  = i_num;
                count_d = 2'd2;
            end
        end

        // display follows the buffer one cycle later; blink-off phase blanks both
        seg_tens_d = (blink_on_q && count_q == 2'd2) ? seg7(tens_q) : SEG_BLANK;
        seg_ones_d = (blink_on_q && count_q != 2'd0) ? seg7(ones_q) : SEG_BLANK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q       <= 4'd0;
            ones_q       <= 4'd0;
            count_q      <= 2'd0;
            overflow_q   <= 1'b0;
            bad_digit_q  <= 1'b0;
            operand_q    <= 7'd0;
            operand_dv_q <= 1'b0;
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
            seg_tens_q   <= SEG_BLANK;
            seg_ones_q   <= SEG_BLANK;
        end else begin
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            bad_digit_q  <= bad_digit_d;
            operand_q    <= operand_d;
            operand_dv_q <= operand_dv_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_on_q   <= blink_on_d;
            seg_tens_q   <= seg_tens_d;
            seg_ones_q   <= seg_ones_d;
        end
    end

    assign o_operand    = operand_q;
    assign o_operand_DV = operand_dv_q;
    assign o_overflow   = overflow_q;
    assign o_bad_digit  = bad_digit_q;
    assign o_seg_tens   = seg_tens_q;
    assign o_seg_ones   = seg_ones_q;

endmodule

// File: tb/tb_digit_entry_display.sv
// tb/tb_digit_entry_display.sv - randomized model-checked bench for digit_entry_display

module tb_digit_entry_display;

    localparam int B = 4;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic [3:0] i_num   = 4'd0;
    logic       i_DV    = 1'b0;
    logic       i_clear = 1'b0;
    logic       i_enter = 1'b0;
    logic [6:0] o_operand;
    logic       o_operand_DV;
    logic       o_overflow;
    logic       o_bad_digit;
    logic [6:0] o_seg_tens;
    logic [6:0] o_seg_ones;

    int n_total = 0;
    int n_bad   = 0;

    digit_entry_display #(.BLINK_CYCLES(B)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_num        (i_num),
        .i_DV         (i_DV),
        .i_clear      (i_clear),
        .i_enter      (i_enter),
        .o_operand    (o_operand),
        .o_operand_DV (o_operand_DV),
        .o_overflow   (o_overflow),
        .o_bad_digit  (o_bad_digit),
        .o_seg_tens   (o_seg_tens),
        .o_seg_ones   (o_seg_ones)
    );

    always #5 clk = ~clk;

    // reference model: the entry is a list of decimal digits, blink phase is
    // derived from how many clock edges overflow has been standing
    int         m_q[$];
    bit         m_ovf       = 1'b0;
    int         m_ovf_edges = 0;
    bit         m_phase_on;
    bit         m_bad;
    int         e_operand   = 0;
    bit         e_dv        = 1'b0;
    bit         e_bad       = 1'b0;
    logic [6:0] e_tens      = 7'h7f;
    logic [6:0] e_ones      = 7'h7f;

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        return tbl[d];
    endfunction

    function automatic int entry_value(input int q[$]);
        int v = 0;
        foreach (q[i]) v = v * 10 + q[i];
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_ovf       = 1'b0;
            m_ovf_edges = 0;
            e_operand   = 0;
            e_dv        = 1'b0;
            e_bad       = 1'b0;
            e_tens      = 7'h7f;
            e_ones      = 7'h7f;
        end else begin
            m_phase_on = !m_ovf || ((m_ovf_edges / B) % 2 == 0);
            e_tens = (m_phase_on && m_q.size() == 2) ? seg_of(m_q[0]) : 7'h7f;
            e_ones = (m_phase_on && m_q.size() != 0) ? seg_of(m_q[m_q.size()-1]) : 7'h7f;
            m_bad  = i_DV && (i_num > 4'd9);
            e_bad  = m_bad;
            e_dv   = 1'b0;
            if (!m_bad && (i_clear || i_enter)) begin
                if (!i_clear) begin
                    e_operand = entry_value(m_q);
                    e_dv      = 1'b1;
                end
                m_q.delete();
                m_ovf       = 1'b0;
                m_ovf_edges = 0;
            end else begin
                if (m_ovf) m_ovf_edges++;
                if (!m_bad && i_DV) begin
                    if (m_q.size() < 2) m_q.push_back(int'(i_num));
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        chk("operand",    32'(o_operand),    32'(e_operand));
        chk("operand_dv", 32'(o_operand_DV), 32'(e_dv));
        chk("overflow",   32'(o_overflow),   32'(m_ovf));
        chk("bad_digit",  32'(o_bad_digit),  32'(e_bad));
        chk("seg_tens",   32'(o_seg_tens),   32'(e_tens));
        chk("seg_ones",   32'(o_seg_ones),   32'(e_ones));
    endtask

    // one clock cycle: drive at negedge, strobes drop after the edge, compare at next negedge
    task automatic step(input bit dv, input logic [3:0] num, input bit clr, input bit ent);
        i_DV    = dv;
        i_num   = num;
        i_clear = clr;
        i_enter = ent;
        @(posedge clk);
        #1;
        i_DV    = 1'b0;
        i_clear = 1'b0;
        i_enter = 1'b0;
        @(negedge clk);
        cmp_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic async_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_operand",   32'(o_operand),    32'd0);
        chk("rst_dv",        32'(o_operand_DV), 32'd0);
        chk("rst_overflow",  32'(o_overflow),   32'd0);
        chk("rst_bad",       32'(o_bad_digit),  32'd0);
        chk("rst_seg_tens",  32'(o_seg_tens),   32'h7f);
        chk("rst_seg_ones",  32'(o_seg_ones),   32'h7f);
        cmp_all();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("init_operand",  32'(o_operand),   32'd0);
        chk("init_seg_tens", 32'(o_seg_tens),  32'h7f);
        chk("init_seg_ones", 32'(o_seg_ones),  32'h7f);
        chk("init_overflow", 32'(o_overflow),  32'd0);
        cmp_all();
        #2 rst_n = 1'b1;

        // 4,2 then enter
        step(1'b1, 4'd4, 1'b0, 1'b0);
        step(1'b1, 4'd2, 1'b0, 1'b0);
        idle(1);
        chk("lit_42_tens", 32'(o_seg_tens), 32'b1001100);
        chk("lit_42_ones", 32'(o_seg_ones), 32'b0010010);
        step(1'b0, 4'd0, 1'b0, 1'b1);
        chk("lit_42_operand", 32'(o_operand),    32'd42);
        chk("lit_42_dv",      32'(o_operand_DV), 32'd1);
        idle(1);
        chk("lit_42_dv_drop", 32'(o_operand_DV), 32'd0);
        chk("lit_blank_tens", 32'(o_seg_tens),   32'h7f);
        chk("lit_blank_ones", 32'(o_seg_ones),   32'h7f);

        // single digit 7
        step(1'b1, 4'd7, 1'b0, 1'b0);
        idle(1);
        chk("lit_7_tens", 32'(o_seg_tens), 32'h7f);
        chk("lit_7_ones", 32'(o_seg_ones), 32'b0001111);
        step(1'b0, 4'd0, 1'b0, 1'b1);
        chk("lit_7_operand", 32'(o_operand), 32'd7);

        // overflow and blink
        step(1'b1, 4'd1, 1'b0, 1'b0);
        step(1'b1, 4'd2, 1'b0, 1'b0);
        step(1'b1, 4'd3, 1'b0, 1'b0);
        chk("lit_ovf_set", 32'(o_overflow), 32'd1);
        idle(4);
        chk("lit_blink_on",  32'(o_seg_tens), 32'b1001111);
        idle(1);
        chk("lit_blink_off", 32'(o_seg_tens), 32'h7f);
        idle(12);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("lit_ovf_clear", 32'(o_overflow), 32'd0);
        idle(2);

        // bad digit keeps the entry
        step(1'b1, 4'd3, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 4'd12, 1'b0, 1'b1);
        chk("lit_bad_pulse", 32'(o_bad_digit), 32'd1);
        idle(1);
        chk("lit_bad_drop",  32'(o_bad_digit), 32'd0);
        chk("lit_bad_ones",  32'(o_seg_ones),  32'b0000110);
        step(1'b0, 4'd0, 1'b1, 1'b0);

        // digit coinciding with enter, then clear+enter
        step(1'b1, 4'd5, 1'b0, 1'b0);
        step(1'b1, 4'd9, 1'b0, 1'b1);
        chk("lit_5_operand", 32'(o_operand),    32'd5);
        chk("lit_5_dv",      32'(o_operand_DV), 32'd1);
        step(1'b1, 4'd6, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        chk("lit_clr_ent_dv", 32'(o_operand_DV), 32'd0);
        idle(2);

        // asynchronous reset mid-entry
        step(1'b1, 4'd8, 1'b0, 1'b0);
        step(1'b1, 4'd8, 1'b0, 1'b0);
        async_reset();
        step(1'b0, 4'd0, 1'b0, 1'b1);
        chk("lit_rst_operand", 32'(o_operand),    32'd0);
        chk("lit_rst_dv",      32'(o_operand_DV), 32'd1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) < 3) begin
                async_reset();
            end else begin
                bit         dv;
                logic [3:0] num;
                dv  = ($urandom_range(0, 99) < 45);
                num = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 9))
                                                  : 4'($urandom_range(10, 15));
                step(dv, num, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 8);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
